// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: edge-detected, maskable sources offered to the
// pipeline through a req/ack handshake, one in service until the pipeline signals RTI.
module irq_controller #(
    parameter int                    NUM_IRQ    = 4,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] VEC_BASE   = 16'h0000,
    localparam int                   ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_IRQ-1:0]    irq_in,
    input  logic                  mask_we,
    input  logic [NUM_IRQ-1:0]    mask_wdata,
    output logic [NUM_IRQ-1:0]    mask_q,
    output logic [NUM_IRQ-1:0]    pending,
    output logic                  irq_req,
    output logic [DATA_WIDTH-1:0] irq_vec,
    output logic [ID_W-1:0]       irq_id,
    input  logic                  irq_ack,
    input  logic                  irq_done,
    output logic                  in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [NUM_IRQ-1:0]      prev_r;
    logic [NUM_IRQ-1:0]      pending_r;
    logic [NUM_IRQ-1:0]      mask_r;
    logic [ID_W-1:0]         id_r;
    logic [DATA_WIDTH-1:0]   vec_r;
    logic [NUM_IRQ-1:0]      event_s;
    logic [NUM_IRQ-1:0]      eligible_s;
    logic [NUM_IRQ-1:0]      clr_s;
    logic                    win_valid_s;
    logic [ID_W-1:0]         win_id_s;
    logic                    grant_s;

    // Slot address for a source; wraps modulo 2^DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] vec_addr(input logic [ID_W-1:0] id);
        logic [DATA_WIDTH-1:0] off;
        off = DATA_WIDTH'(id);
        return VEC_BASE + (off << 1);
    endfunction

    assign event_s    = irq_in & ~prev_r;
    assign eligible_s = pending_r & mask_r;

    // Lowest eligible index wins.
    always_comb begin
        win_valid_s = 1'b0;
        win_id_s    = {ID_W{1'b0}};
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible_s[i]) begin
                win_valid_s = 1'b1;
                win_id_s    = ID_W'(i);
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Next-state and pending-clear decode.
    always_comb begin
        state_next_s = state_r;
        clr_s        = {NUM_IRQ{1'b0}};
        grant_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    grant_s      = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    clr_s[id_r]  = 1'b1;
                    state_next_s = ST_SERVICE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SERVICE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register plus the id/vector latched at grant time.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            id_r    <= {ID_W{1'b0}};
            vec_r   <= VEC_BASE;
        end else begin
            state_r <= state_next_s;
            if (grant_s) begin
                id_r  <= win_id_s;
                vec_r <= vec_addr(win_id_s);
            end
        end
    end

    // Edge history, mask and pending flags; a new event beats a same-edge clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_r    <= {NUM_IRQ{1'b0}};
            pending_r <= {NUM_IRQ{1'b0}};
            mask_r    <= {NUM_IRQ{1'b1}};
        end else begin
            prev_r    <= irq_in;
            pending_r <= (pending_r & ~clr_s) | event_s;
            if (mask_we) begin
                mask_r <= mask_wdata;
            end
        end
    end

    assign mask_q     = mask_r;
    assign pending    = pending_r;
    assign irq_id     = id_r;
    assign irq_vec    = vec_r;
    assign irq_req    = (state_r == ST_REQ);
    assign in_service = (state_r == ST_SERVICE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: each task drives one scenario and checks
// hand-computed values sampled 1 time unit after the rising edge.
module tb_irq_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_in;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic [3:0]  mask_q;
    logic [3:0]  pending;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic [1:0]  irq_id;
    logic        irq_ack;
    logic        irq_done;
    logic        in_service;

    int checks = 0;
    int errors = 0;

    irq_controller #(.NUM_IRQ(4), .DATA_WIDTH(16), .VEC_BASE(16'h0000)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask_q(mask_q), .pending(pending),
        .irq_req(irq_req), .irq_vec(irq_vec), .irq_id(irq_id),
        .irq_ack(irq_ack), .irq_done(irq_done), .in_service(in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; irq_in = 4'b0000; mask_we = 1'b0; mask_wdata = 4'b0000;
        irq_ack = 1'b0; irq_done = 1'b0;
        tick(); tick();
        reset = 1'b1;
        checks++;
        if ({irq_req, in_service, pending, mask_q} !== {1'b0, 1'b0, 4'b0000, 4'b1111}) begin
            errors++;
            $display("FAIL reset_ctl got req=%b svc=%b pend=%b mask=%b want 0 0 0000 1111",
                     irq_req, in_service, pending, mask_q);
        end
        checks++;
        if ({irq_id, irq_vec} !== {2'd0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_vec got id=%0d vec=%h want 0 0000", irq_id, irq_vec);
        end
    endtask

    task automatic test_single();
        irq_in = 4'b0100; tick();  // edge k
        irq_in = 4'b0000;
        checks++;
        if ({pending, irq_req} !== {4'b0100, 1'b0}) begin
            errors++;
            $display("FAIL single_pend got pend=%b req=%b want 0100 0", pending, irq_req);
        end
        tick();  // k+1
        checks++;
        if ({irq_req, irq_id, irq_vec} !== {1'b1, 2'd2, 16'h0004}) begin
            errors++;
            $display("FAIL single_req got req=%b id=%0d vec=%h want 1 2 0004", irq_req, irq_id, irq_vec);
        end
        tick();  // k+2
        irq_ack = 1'b1; tick();  // k+3
        irq_ack = 1'b0;
        checks++;
        if ({irq_req, in_service, pending} !== {1'b0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL single_ack got req=%b svc=%b pend=%b want 0 1 0000", irq_req, in_service, pending);
        end
        tick(); tick();  // k+5
        checks++;
        if ({in_service, irq_id, irq_vec} !== {1'b1, 2'd2, 16'h0004}) begin
            errors++;
            $display("FAIL single_hold got svc=%b id=%0d vec=%h want 1 2 0004", in_service, irq_id, irq_vec);
        end
        irq_done = 1'b1; tick();  // k+6
        irq_done = 1'b0;
        checks++;
        if ({in_service, irq_req} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_done got svc=%b req=%b want 0 0", in_service, irq_req);
        end
    endtask

    task automatic test_priority();
        irq_in = 4'b1010; tick();
        irq_in = 4'b0000; tick();
        checks++;
        if ({irq_req, irq_id, irq_vec, pending} !== {1'b1, 2'd1, 16'h0002, 4'b1010}) begin
            errors++;
            $display("FAIL prio_first got req=%b id=%0d vec=%h pend=%b want 1 1 0002 1010",
                     irq_req, irq_id, irq_vec, pending);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        checks++;
        if ({irq_req, in_service} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL prio_gap got req=%b svc=%b want 0 0", irq_req, in_service);
        end
        tick();
        checks++;
        if ({irq_req, irq_id, irq_vec} !== {1'b1, 2'd3, 16'h0006}) begin
            errors++;
            $display("FAIL prio_second got req=%b id=%0d vec=%h want 1 3 0006", irq_req, irq_id, irq_vec);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        checks++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL prio_drain got pend=%b want 0000", pending);
        end
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_wdata = 4'b1110; tick();
        mask_we = 1'b0;
        checks++;
        if (mask_q !== 4'b1110) begin
            errors++;
            $display("FAIL mask_write got mask=%b want 1110", mask_q);
        end
        irq_in = 4'b0001; tick();
        irq_in = 4'b0000; tick(); tick();
        checks++;
        if ({pending, irq_req} !== {4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL mask_block got pend=%b req=%b want 0001 0", pending, irq_req);
        end
        mask_we = 1'b1; mask_wdata = 4'b1111; tick();
        mask_we = 1'b0;
        checks++;
        if ({mask_q, irq_req} !== {4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL mask_unmask got mask=%b req=%b want 1111 0", mask_q, irq_req);
        end
        tick();
        checks++;
        if ({irq_req, irq_id, irq_vec} !== {1'b1, 2'd0, 16'h0000}) begin
            errors++;
            $display("FAIL mask_req got req=%b id=%0d vec=%h want 1 0 0000", irq_req, irq_id, irq_vec);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;
    endtask

    task automatic test_collision();
        irq_in = 4'b0100; tick();
        irq_in = 4'b0000; tick();
        checks++;
        if ({irq_req, irq_id} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL coll_req got req=%b id=%0d want 1 2", irq_req, irq_id);
        end
        irq_ack = 1'b1; irq_in = 4'b0100; tick();
        irq_ack = 1'b0; irq_in = 4'b0000;
        checks++;
        if ({pending, in_service, irq_req} !== {4'b0100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL coll_setwins got pend=%b svc=%b req=%b want 0100 1 0", pending, in_service, irq_req);
        end
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        tick();
        checks++;
        if ({irq_req, irq_id, irq_vec} !== {1'b1, 2'd2, 16'h0004}) begin
            errors++;
            $display("FAIL coll_second got req=%b id=%0d vec=%h want 1 2 0004", irq_req, irq_id, irq_vec);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        mask_we = 1'b1; mask_wdata = 4'b0101; tick(); mask_we = 1'b0;
        irq_in = 4'b0001; tick();
        irq_in = 4'b0000; tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_in = 4'b0010; tick(); irq_in = 4'b0000;
        checks++;
        if ({in_service, pending} !== {1'b1, 4'b0010}) begin
            errors++;
            $display("FAIL rst_pre got svc=%b pend=%b want 1 0010", in_service, pending);
        end
        reset = 1'b0; tick(); reset = 1'b1;
        checks++;
        if ({in_service, irq_req, pending, mask_q, irq_id} !== {1'b0, 1'b0, 4'b0000, 4'b1111, 2'd0}) begin
            errors++;
            $display("FAIL rst_mid got svc=%b req=%b pend=%b mask=%b id=%0d want 0 0 0000 1111 0",
                     in_service, irq_req, pending, mask_q, irq_id);
        end
        irq_in = 4'b1000; tick();
        irq_in = 4'b0000; tick();
        checks++;
        if ({irq_req, irq_id, irq_vec} !== {1'b1, 2'd3, 16'h0006}) begin
            errors++;
            $display("FAIL rst_resume got req=%b id=%0d vec=%h want 1 3 0006", irq_req, irq_id, irq_vec);
        end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
